icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Responder end of the datapath-cache instruction port: services imemREN/imemaddr from the
//  pipeline datapath and returns ihit/imemload. Direct-mapped, one-word-block instruction cache
//  with a blocking miss FSM that fetches from the memory controller (iREN/iaddr/iwait/iload).
//  Sits between the datapath's fetch side and the memory controller's instruction port.
// PARAMETERS
//  SETS      16  number of frames; power of two, >=2; IDXW = $clog2(SETS)
//  TAGW      30-IDXW  tag width (derived localparam, not overridable)
// PORTS
//  CLK        in   1   clock; all state updates on posedge CLK
//  RST        in   1   reset, synchronous, active-high
//  imemREN    in   1   datapath instruction read request
//  imemaddr   in   32  datapath instruction byte address; bits [1:0] ignored
//  ihit       out  1   requested word valid on imemload this cycle
//  imemload   out  32  instruction word; meaningful only when ihit=1
//  iREN       out  1   read request to memory controller
//  iaddr      out  32  word-aligned address to memory controller ({imemaddr[31:2],2'b00})
//  iwait      in   1   memory controller busy; iload valid when iREN=1 and iwait=0
//  iload      in   32  fill data from memory controller
//  hit_count  out  32  (ICACHE_PERF_EN only) hit counter
//  miss_count out  32  (ICACHE_PERF_EN only) miss counter
// BEHAVIOUR
//  Address split: tag=imemaddr[31:IDXW+2], idx=imemaddr[IDXW+1:2], byte offset [1:0] ignored.
//  Frame = {valid, tag, data}; all SETS frames valid=0, tag=0, data=0 on reset.
//  FSM states: IDLE, FETCH. Reset -> IDLE.
//  IDLE: ihit = imemREN & valid[idx] & (tag[idx]==tag); imemload = data[idx] (combinational,
//   zero-latency hit). iREN=0. imemREN & miss -> FETCH next cycle. imemREN=0 -> stay, ihit=0.
//  FETCH: ihit=0, iREN=imemREN, iaddr tracks current imemaddr combinationally.
//   iwait=0 & imemREN=1: write frame[idx] <= {1, tag, iload}; -> IDLE; hit next cycle.
//   imemREN=0 (halt/redirect drop): abort, no fill, -> IDLE. Abort has priority over fill.
//   imemaddr changes mid-FETCH: fill uses address present on the completing cycle.
//  Miss latency: 1 (detect) + memory wait cycles + 1 (hit from filled frame).
//  Fill replaces any existing frame at idx unconditionally (no LRU, direct-mapped).
//  RST asserted mid-FETCH: return to IDLE, iREN=0 next cycle, all frames invalidated.
//  Reset values: ihit=0, iREN=0, imemload=0, iaddr follows imemaddr, counters 0.
//  No write path: cache is read-only; self-modifying code not supported.
// CONFIGURATION
//  ICACHE_PERF_EN defined: hit_count increments on every cycle with ihit=1; miss_count
//   increments on each IDLE->FETCH transition; both 32-bit, wrap at 2^32, cleared by RST.
//  Undefined: hit_count/miss_count ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  cpu_types_pkg: word_t (existing); add icachef_t packed struct {tag, idx, bytoff} for
//   address split, icache_frame_t {valid, tag, data}, icache_state_t enum {IDLE, FETCH}.
//  One sub-module: icache_frames (SETS-entry frame array, sync write on fill, async read
//   by idx, sync clear on RST). FSM, hit compare and counters stay in icache_responder.
// TESTING
//  1 Cold miss: RST, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with
//    iload=0x2001_0005 -> iREN high 4 cycles, ihit=1 next cycle, imemload=0x2001_0005.
//  2 Hit after fill: repeat addr 0x40 -> ihit=1 same cycle, iREN=0, no FSM change.
//  3 Conflict: SETS=16, fill 0x40 then 0x80 (same idx 0) -> 0x80 fills; 0x40 then misses.
//  4 Abort: miss on 0x44, drop imemREN in FETCH with iwait=1 -> IDLE, iREN=0, frame 1 stays
//    invalid; re-request 0x44 misses again.
//  5 Reset mid-FETCH: RST during FETCH -> IDLE, iREN=0, prior hit on 0x40 now misses.
//  6 ICACHE_PERF_EN: sequence of tests 1-2 -> miss_count=1, hit_count=2.

Source files
------------

// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction cache responder.
// Address split, frame layout and miss FSM state encoding.
package icache_responder_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;
  localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAGW = 30 - ICACHE_IDXW;

  // Byte address split for the default geometry.
  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;

  // One direct-mapped frame for the default geometry.
  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Word-align a byte address for the memory controller.
  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Datapath fetch port plus memory controller instruction port.
// slave = cache side, master = environment (datapath + memory controller).
interface icache_responder_if;
  import icache_responder_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder_frames.sv
// Direct-mapped frame store: SETS x {valid, tag, data}.
// Synchronous write on fill, asynchronous read by index, synchronous clear.
module icache_responder_frames #(
  parameter int SETS = 16,
  parameter int IDXW = $clog2(SETS),
  parameter int TAGW = 30 - IDXW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            we,
  input  logic [IDXW-1:0] widx,
  input  logic [TAGW-1:0] wtag,
  input  logic [31:0]     wdata,
  input  logic [IDXW-1:0] ridx,
  output logic            rvalid,
  output logic [TAGW-1:0] rtag,
  output logic [31:0]     rdata
);

  logic [SETS-1:0]           valid_q;
  logic [SETS-1:0][TAGW-1:0] tag_q;
  logic [SETS-1:0][31:0]     data_q;

  // Clear every frame on reset; otherwise overwrite the indexed frame on fill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
      tag_q[widx]   <= wtag;
      data_q[widx]  <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache with a blocking miss FSM.
// Hits are combinational (zero latency); a miss stalls in FETCH until the
// memory controller drops iwait, or the datapath drops imemREN (abort).
// Optional feature macro: ICACHE_PERF_EN adds hit_count / miss_count.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic  CLK,
  input  logic  RST,
  icache_responder_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;

  icache_state_t state_q, state_d;

  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic            fr_valid;
  logic [TAGW-1:0] fr_tag;
  word_t           fr_data;
  logic            lookup_hit;
  logic            fill;
  logic            unused_bytoff;

  assign req_tag       = bus.imemaddr[31:IDXW+2];
  assign req_idx       = bus.imemaddr[IDXW+1:2];
  assign unused_bytoff = ^bus.imemaddr[1:0];

  assign lookup_hit = fr_valid && (fr_tag == req_tag);
  // Abort (imemREN low) wins over a completing fill.
  assign fill = (state_q == FETCH) && bus.imemREN && !bus.iwait && !RST;

  icache_responder_frames #(
    .SETS (SETS),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_frames (
    .CLK    (CLK),
    .RST    (RST),
    .we     (fill),
    .widx   (req_idx),
    .wtag   (req_tag),
    .wdata  (bus.iload),
    .ridx   (req_idx),
    .rvalid (fr_valid),
    .rtag   (fr_tag),
    .rdata  (fr_data)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: miss enters FETCH; fill or abort returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.imemREN && !lookup_hit) state_d = FETCH;
      FETCH: if (!bus.imemREN || !bus.iwait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: hit only from IDLE; memory request only while fetching.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.iREN     = 1'b0;
    bus.imemload = '0;
    bus.iaddr    = word_align(bus.imemaddr);
    if (!RST) begin
      bus.imemload = fr_data;
      unique case (state_q)
        IDLE:  bus.ihit = bus.imemREN && lookup_hit;
        FETCH: bus.iREN = bus.imemREN;
        default: ;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  // Hit counter counts ihit cycles; miss counter counts IDLE->FETCH entries.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit) hit_count <= hit_count + 32'd1;
      if (state_q == IDLE && state_d == FETCH) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, hit, conflict, abort,
// mid-FETCH address change, reset mid-FETCH, optional perf counters.
module tb_icache_responder;
  import icache_responder_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;

  icache_responder_if bus ();

`ifdef ICACHE_PERF_EN
  word_t hit_count, miss_count;
`endif

  icache_responder #(.SETS(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here,
  // outputs are sampled #1 later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int ren_cycles;

  initial begin
    RST = 1'b1;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    bus.iwait = 1'b1;
    bus.iload = '0;
    tick(); tick();
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    settle();
    chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("rst_iren", {31'd0, bus.iREN}, 32'd0);
    chk("rst_load", bus.imemload, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'h0000_0040);

    // 1 cold miss: 3 wait cycles then data
    tick();
    RST = 1'b0;
    settle();
    chk("t1_detect_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("t1_detect_iren", {31'd0, bus.iREN}, 32'd0);
    ren_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        bus.iwait = 1'b0;
        bus.iload = 32'h2001_0005;
      end
      settle();
      if (bus.iREN) ren_cycles++;
      chk("t1_fetch_ihit", {31'd0, bus.ihit}, 32'd0);
    end
    chk("t1_ren_cycles", ren_cycles, 32'd4);
    chk("t1_iaddr", bus.iaddr, 32'h0000_0040);
    tick();
    bus.iwait = 1'b1;
    bus.iload = 32'hDEAD_BEEF;
    settle();
    chk("t1_hit", {31'd0, bus.ihit}, 32'd1);
    chk("t1_load", bus.imemload, 32'h2001_0005);

    // 2 hit again, byte offset ignored
    tick();
    bus.imemaddr = 32'h0000_0043;
    settle();
    chk("t2_hit", {31'd0, bus.ihit}, 32'd1);
    chk("t2_iren", {31'd0, bus.iREN}, 32'd0);
    chk("t2_load", bus.imemload, 32'h2001_0005);
    tick();
    bus.imemREN = 1'b0;
    settle();
    chk("t2_noren_ihit", {31'd0, bus.ihit}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("t6_hit_count", hit_count, 32'd2);
    chk("t6_miss_count", miss_count, 32'd1);
`endif

    // 3 conflict: 0x80 shares idx 0 with 0x40
    tick();
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0080;
    settle();
    chk("t3_miss", {31'd0, bus.ihit}, 32'd0);
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'hAAAA_0080;
    settle();
    chk("t3_iren", {31'd0, bus.iREN}, 32'd1);
    chk("t3_iaddr", bus.iaddr, 32'h0000_0080);
    tick();
    bus.iwait = 1'b1;
    settle();
    chk("t3_hit80", {31'd0, bus.ihit}, 32'd1);
    chk("t3_load80", bus.imemload, 32'hAAAA_0080);
    tick();
    bus.imemaddr = 32'h0000_0040;
    settle();
    chk("t3_evict40", {31'd0, bus.ihit}, 32'd0);
    tick();
    bus.imemREN = 1'b0;
    tick();

    // 4 abort on 0x44: fill data present but imemREN low
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0044;
    settle();
    chk("t4_miss", {31'd0, bus.ihit}, 32'd0);
    tick();
    settle();
    chk("t4_iren", {31'd0, bus.iREN}, 32'd1);
    bus.imemREN = 1'b0;
    bus.iwait = 1'b0;
    bus.iload = 32'h1111_2222;
    settle();
    chk("t4_abort_iren", {31'd0, bus.iREN}, 32'd0);
    tick();
    bus.iwait = 1'b1;
    bus.imemREN = 1'b1;
    settle();
    chk("t4_idle_iren", {31'd0, bus.iREN}, 32'd0);
    chk("t4_remiss", {31'd0, bus.ihit}, 32'd0);
    tick();
    settle();
    chk("t4_refetch_iren", {31'd0, bus.iREN}, 32'd1);
    bus.imemREN = 1'b0;
    tick();

    // address change mid-FETCH: 0x4C then 0x8C (same idx 3)
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_004C;
    tick();
    bus.imemaddr = 32'h0000_008C;
    bus.iwait = 1'b0;
    bus.iload = 32'h0000_8C8C;
    settle();
    chk("mid_iaddr", bus.iaddr, 32'h0000_008C);
    tick();
    bus.iwait = 1'b1;
    settle();
    chk("mid_hit8c", {31'd0, bus.ihit}, 32'd1);
    chk("mid_load8c", bus.imemload, 32'h0000_8C8C);
    bus.imemaddr = 32'h0000_004C;
    settle();
    chk("mid_miss4c", {31'd0, bus.ihit}, 32'd0);
    tick();
    bus.imemREN = 1'b0;
    tick();

    // 5 reset mid-FETCH: refill 0x40, then reset during a 0x48 miss
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'h1234_5678;
    tick();
    bus.iwait = 1'b1;
    settle();
    chk("t5_hit40", {31'd0, bus.ihit}, 32'd1);
    bus.imemaddr = 32'h0000_0048;
    tick();
    settle();
    chk("t5_fetch_iren", {31'd0, bus.iREN}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.imemREN = 1'b0;
    settle();
    chk("t5_post_iren", {31'd0, bus.iREN}, 32'd0);
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    settle();
    chk("t5_miss40", {31'd0, bus.ihit}, 32'd0);
    chk("t5_load0", bus.imemload, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("t5_hit_clr", hit_count, 32'd0);
    chk("t5_miss_clr", miss_count, 32'd0);
`endif
    tick();
    settle();
    chk("t5_refetch_iren", {31'd0, bus.iREN}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
